// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-side arbiter.
// The read-side scheduler uses the same helpers.
package fifo_arb_pkg;

   typedef enum logic {
      ARB_IDLE,
      ARB_OWN
   } arb_state_t;

   localparam int DEF_NUM_REQ    = 4;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_MAX_BURST  = 4;

   localparam int OWNER_W = $clog2(DEF_NUM_REQ);
   localparam int CNT_W   = $clog2(DEF_MAX_BURST + 1);

   function automatic int owner_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int count_width(input int m);
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Producer-side requests and FIFO write port seen by the write arbiter.
// master: the arbiter. slave: the producers and the FIFO.
interface fifo_write_arbiter_if
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

   localparam int OW = owner_width(NUM_REQ);

   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_last;
   logic [NUM_REQ-1:0]            gnt;
   logic                          fifo_full;
   logic                          fifo_write_enable;
   logic [DATA_WIDTH-1:0]         fifo_write_data;
   logic [OW-1:0]                 owner;
   logic                          busy;

   modport master (
      input  req, req_data, req_last, fifo_full,
      output gnt, fifo_write_enable, fifo_write_data, owner, busy
   );

   modport slave (
      output req, req_data, req_last, fifo_full,
      input  gnt, fifo_write_enable, fifo_write_data, owner, busy
   );

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin pick: first set request after last, wrapping.
// Shared between the write arbiter and the read-side scheduler.
module rr_priority_picker
   import fifo_arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]              req,
   input  logic [owner_width(N)-1:0] last,
   output logic                      found,
   output logic [owner_width(N)-1:0] pick
);

   localparam int OW = owner_width(N);

   // Walk from the farthest candidate to the nearest so the nearest wins.
   always_comb begin
      int idx;
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      for (int k = N; k >= 1; k--) begin
         idx = (int'(last) + k) % N;
         if (req[idx]) begin
            found = 1'b1;
            pick  = OW'(idx);
         end
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin owner of the FIFO write port; one burst of up to MAX_BURST
// words per ownership, one IDLE bubble between bursts.
//
//   state    | meaning
//   ARB_IDLE | no owner; pick next requester after last_owner
//   ARB_OWN  | owner's words go to the FIFO whenever it is not full
module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int MAX_BURST  = DEF_MAX_BURST
) (
   input logic                 clk,
   input logic                 rst,
   fifo_write_arbiter_if.master bus
);

   localparam int OW = owner_width(NUM_REQ);
   localparam int CW = count_width(MAX_BURST);
   localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);
   localparam logic [OW-1:0] RST_LAST = OW'(NUM_REQ - 1);

   arb_state_t       state;
   logic [OW-1:0]    owner;
   logic [OW-1:0]    last_owner;
   logic [CW-1:0]    burst_cnt;
   logic [OW-1:0]    pick;
   logic [OW-1:0]    sel;
   logic             found;
   logic             own;
   logic             accept;
   logic             done;
   logic [NUM_REQ-1:0] gnt;

   rr_priority_picker #(.N(NUM_REQ)) u_picker (
      .req   (bus.req),
      .last  (last_owner),
      .found (found),
      .pick  (pick)
   );

   assign own    = (state == ARB_OWN);
   assign accept = own & bus.req[owner] & ~bus.fifo_full;
   assign done   = accept & (bus.req_last[owner] | (burst_cnt == LAST_CNT));

   // Select forced to 0 outside OWN so the data bus is quiet after reset.
   assign sel = own ? owner : '0;

   always_comb begin
      gnt        = '0;
      gnt[owner] = accept;
   end

   assign bus.gnt               = gnt;
   assign bus.fifo_write_enable = accept;
   assign bus.fifo_write_data   = bus.req_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
   assign bus.owner             = owner;
   assign bus.busy              = own;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ARB_IDLE;
         owner      <= '0;
         last_owner <= RST_LAST;
         burst_cnt  <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (found) begin
                  owner     <= pick;
                  burst_cnt <= '0;
                  state     <= ARB_OWN;
               end
            end
            ARB_OWN: begin
               if (accept) begin
                  burst_cnt <= burst_cnt + CW'(1);
               end
               // A full FIFO holds ownership; only withdrawal or completion ends it.
               if (!bus.req[owner] || done) begin
                  state      <= ARB_IDLE;
                  last_owner <= owner;
               end
            end
         endcase
      end
   end

endmodule
